// File: rtl/alu_exec_stage.sv
// alu_exec_stage: ID/EX register, ALU execute and EX/MEM register with stall/flush hooks
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validD,
  input  logic [WIDTH-1:0] srcaD,
  input  logic [WIDTH-1:0] srcbD,
  input  logic [2:0]       alucontrolD,
  input  logic             regwriteD,
  input  logic [4:0]       writeregD,
  input  logic             stall,
  input  logic             flushE,
  output logic             validE,
  output logic             regwriteE,
  output logic [4:0]       writeregE,
  output logic             validM,
  output logic [WIDTH-1:0] aluoutM,
  output logic             zeroM,
  output logic             overflowM,
  output logic             illegalM,
  output logic             regwriteM,
  output logic [4:0]       writeregM
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  logic             valid_e_q, valid_e_d, rw_e_q, rw_e_d;
  logic [WIDTH-1:0] a_e_q, a_e_d, b_e_q, b_e_d;
  logic [2:0]       ctl_e_q, ctl_e_d;
  logic [4:0]       wr_e_q, wr_e_d, wr_m_q, wr_m_d;
  logic             valid_m_q, valid_m_d, zero_m_q, zero_m_d, ovf_m_q, ovf_m_d;
  logic             ill_m_q, ill_m_d, rw_m_q, rw_m_d;
  logic [WIDTH-1:0] alu_m_q, alu_m_d;
  logic             keep_e, load_e, ovf, ill;
  logic [WIDTH-1:0] sum, diff, res;
  always_comb begin
    keep_e    = stall & ~flushE;
    load_e    = ~stall & ~flushE & validD;
    valid_e_d = keep_e ? valid_e_q : load_e;
    a_e_d     = keep_e ? a_e_q : load_e ? srcaD : '0;
    b_e_d     = keep_e ? b_e_q : load_e ? srcbD : '0;
    ctl_e_d   = keep_e ? ctl_e_q : load_e ? alucontrolD : '0;
    rw_e_d    = keep_e ? rw_e_q : load_e & regwriteD;
    wr_e_d    = keep_e ? wr_e_q : load_e ? writeregD : '0;
    sum  = a_e_q + b_e_q;
    diff = a_e_q - b_e_q;
    res  = ctl_e_q == OP_ADD ? sum :
           ctl_e_q == OP_SUB ? diff :
           ctl_e_q == OP_AND ? a_e_q & b_e_q :
           ctl_e_q == OP_OR  ? a_e_q | b_e_q :
           ctl_e_q == OP_SLT ? WIDTH'($signed(a_e_q) < $signed(b_e_q)) : '0;
    ovf  = ctl_e_q == OP_ADD ? (a_e_q[WIDTH-1] == b_e_q[WIDTH-1]) && (sum[WIDTH-1] != a_e_q[WIDTH-1]) :
           ctl_e_q == OP_SUB ? (a_e_q[WIDTH-1] != b_e_q[WIDTH-1]) && (diff[WIDTH-1] != a_e_q[WIDTH-1]) :
           1'b0;
    ill  = ctl_e_q == 3'b011 || ctl_e_q == 3'b100 || ctl_e_q == 3'b101;
    // a bubble in E lands in M as all zeros
    valid_m_d = stall ? valid_m_q : valid_e_q;
    alu_m_d   = stall ? alu_m_q : valid_e_q ? res : '0;
    zero_m_d  = stall ? zero_m_q : valid_e_q && res == '0;
    ovf_m_d   = stall ? ovf_m_q : valid_e_q & ovf;
    ill_m_d   = stall ? ill_m_q : valid_e_q & ill;
    rw_m_d    = stall ? rw_m_q : valid_e_q & rw_e_q;
    wr_m_d    = stall ? wr_m_q : valid_e_q ? wr_e_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_q <= 1'b0;
      a_e_q     <= '0;
      b_e_q     <= '0;
      ctl_e_q   <= '0;
      rw_e_q    <= 1'b0;
      wr_e_q    <= '0;
      valid_m_q <= 1'b0;
      alu_m_q   <= '0;
      zero_m_q  <= 1'b0;
      ovf_m_q   <= 1'b0;
      ill_m_q   <= 1'b0;
      rw_m_q    <= 1'b0;
      wr_m_q    <= '0;
    end else begin
      valid_e_q <= valid_e_d;
      a_e_q     <= a_e_d;
      b_e_q     <= b_e_d;
      ctl_e_q   <= ctl_e_d;
      rw_e_q    <= rw_e_d;
      wr_e_q    <= wr_e_d;
      valid_m_q <= valid_m_d;
      alu_m_q   <= alu_m_d;
      zero_m_q  <= zero_m_d;
      ovf_m_q   <= ovf_m_d;
      ill_m_q   <= ill_m_d;
      rw_m_q    <= rw_m_d;
      wr_m_q    <= wr_m_d;
    end
  end
  assign validE    = valid_e_q;
  assign regwriteE = rw_e_q & valid_e_q;
  assign writeregE = wr_e_q;
  assign validM    = valid_m_q;
  assign aluoutM   = alu_m_q;
  assign zeroM     = zero_m_q;
  assign overflowM = ovf_m_q;
  assign illegalM  = ill_m_q;
  assign regwriteM = rw_m_q & valid_m_q;
  assign writeregM = wr_m_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed scenarios plus randomized run against a cycle-level reference model
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst, validD, regwriteD, stall, flushE;
  logic [31:0] srcaD, srcbD;
  logic [2:0]  alucontrolD;
  logic [4:0]  writeregD;
  logic        validE, regwriteE, validM, zeroM, overflowM, illegalM, regwriteM;
  logic [4:0]  writeregE, writeregM;
  logic [31:0] aluoutM;
  logic [48:0] obs;
  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .validD(validD), .srcaD(srcaD), .srcbD(srcbD),
    .alucontrolD(alucontrolD), .regwriteD(regwriteD), .writeregD(writeregD),
    .stall(stall), .flushE(flushE), .validE(validE), .regwriteE(regwriteE),
    .writeregE(writeregE), .validM(validM), .aluoutM(aluoutM), .zeroM(zeroM),
    .overflowM(overflowM), .illegalM(illegalM), .regwriteM(regwriteM), .writeregM(writeregM)
  );

  always #5 clk = ~clk;
  assign obs = {validE, regwriteE, writeregE, validM, aluoutM, zeroM, overflowM,
                illegalM, regwriteM, writeregM};

  typedef struct packed {
    logic v; logic [31:0] a; logic [31:0] b; logic [2:0] c; logic rw; logic [4:0] wr;
  } e_t;
  typedef struct packed {
    logic v; logic [31:0] r; logic z; logic ovf; logic ill; logic rw; logic [4:0] wr;
  } m_t;
  e_t me;
  m_t mm;

  // returns {illegal, overflow, result}, computed with 64-bit signed arithmetic
  function automatic logic [33:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s, lim;
    logic [31:0] r;
    logic ovf, ill;
    sa = $signed(a);
    sb = $signed(b);
    lim = 2147483647;
    s = 0;
    ovf = 1'b0;
    ill = 1'b0;
    r = '0;
    case (c)
      3'b010: begin s = sa + sb; r = s[31:0]; ovf = (s > lim) || (s < -lim - 1); end
      3'b110: begin s = sa - sb; r = s[31:0]; ovf = (s > lim) || (s < -lim - 1); end
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    return {ill, ovf, r};
  endfunction

  function automatic logic [48:0] exp_vec();
    return {me.v, me.v & me.rw, me.wr, mm.v, mm.r, mm.z, mm.ovf, mm.ill, mm.v & mm.rw, mm.wr};
  endfunction

  task automatic tick();
    e_t ne;
    m_t nm;
    logic [33:0] x;
    x = ref_alu(me.c, me.a, me.b);
    if (rst) begin
      ne = '0;
      nm = '0;
    end else begin
      nm = stall ? mm : me.v ? m_t'{1'b1, x[31:0], x[31:0] == 0, x[32], x[33], me.rw, me.wr} : '0;
      ne = flushE ? '0 : stall ? me : validD ? e_t'{1'b1, srcaD, srcbD, alucontrolD, regwriteD, writeregD} : '0;
    end
    @(posedge clk);
    #1;
    me = ne;
    mm = nm;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] c, input logic rw, input logic [4:0] wr);
    validD = v; srcaD = a; srcbD = b; alucontrolD = c; regwriteD = rw; writeregD = wr;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flushE = 1'b0;
    drive(1'b1, 32'd3, 32'd4, 3'b010, 1'b1, 5'd1);
    tick(); tick();
    checks++; if (obs !== 49'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_add();
    drive(1'b1, 32'd5, 32'd7, 3'b010, 1'b1, 5'd3);
    tick();
    checks++; if ({validE, regwriteE, writeregE} !== {1'b1, 1'b1, 5'd3}) begin
      errors++; $display("FAIL add_e_stage got=%b exp=%b", {validE, regwriteE, writeregE}, 7'b1100011); end
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (aluoutM !== 32'd12) begin errors++; $display("FAIL add_result got=%0d exp=12", aluoutM); end
    checks++; if ({validM, zeroM, overflowM, regwriteM, writeregM} !== {4'b1001, 5'd3}) begin
      errors++; $display("FAIL add_flags got=%b exp=%b", {validM, zeroM, overflowM, regwriteM, writeregM}, 9'b100100011); end
  endtask

  task automatic test_overflow_slt();
    drive(1'b1, 32'h7FFFFFFF, 32'd1, 3'b010, 1'b1, 5'd4);
    tick();
    drive(1'b1, 32'h80000000, 32'd1, 3'b111, 1'b1, 5'd5);
    tick();
    checks++; if ({overflowM, aluoutM} !== {1'b1, 32'h80000000}) begin
      errors++; $display("FAIL add_overflow got=%b/%h exp=1/80000000", overflowM, aluoutM); end
    drive(1'b1, 32'd9, 32'd9, 3'b110, 1'b1, 5'd6);
    tick();
    checks++; if ({overflowM, aluoutM} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL slt_overflowing_diff got=%b/%h exp=0/1", overflowM, aluoutM); end
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    checks++; if ({validM, zeroM, aluoutM} !== {2'b11, 32'd0}) begin
      errors++; $display("FAIL sub_zero got=%b%b/%h exp=11/0", validM, zeroM, aluoutM); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'd10, 32'd20, 3'b010, 1'b1, 5'd8);
    tick();
    drive(1'b1, 32'd1, 32'd1, 3'b010, 1'b1, 5'd9);
    tick();
    drive(1'b1, 32'd4, 32'd2, 3'b001, 1'b1, 5'd10);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({validM, aluoutM, validE, writeregE} !== {1'b1, 32'd30, 1'b1, 5'd9}) begin
        errors++; $display("FAIL stall_hold[%0d] got=%b/%0d/%b/%0d exp=1/30/1/9", i, validM, aluoutM, validE, writeregE); end
    end
    stall = 1'b0;
    tick();
    checks++; if ({validM, aluoutM, writeregM} !== {1'b1, 32'd2, 5'd9}) begin
      errors++; $display("FAIL stall_release_a got=%b/%0d/%0d exp=1/2/9", validM, aluoutM, writeregM); end
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    checks++; if ({validM, aluoutM, writeregM} !== {1'b1, 32'd6, 5'd10}) begin
      errors++; $display("FAIL stall_release_b got=%b/%0d/%0d exp=1/6/10", validM, aluoutM, writeregM); end
    tick();
    checks++; if (validM !== 1'b0) begin errors++; $display("FAIL stall_no_dup got=%b exp=0", validM); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'd5, 32'd8, 3'b001, 1'b1, 5'd11);
    tick();
    drive(1'b1, 32'd3, 32'd4, 3'b010, 1'b1, 5'd12);
    tick();
    drive(1'b1, 32'd1, 32'd2, 3'b010, 1'b1, 5'd13);
    stall = 1'b1; flushE = 1'b1;
    tick();
    checks++; if ({validE, regwriteE, writeregE} !== 7'd0) begin
      errors++; $display("FAIL flush_e got=%b exp=0000000", {validE, regwriteE, writeregE}); end
    checks++; if ({validM, aluoutM, writeregM} !== {1'b1, 32'd13, 5'd11}) begin
      errors++; $display("FAIL flush_m_held got=%b/%0d/%0d exp=1/13/11", validM, aluoutM, writeregM); end
    stall = 1'b0; flushE = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    checks++; if ({validM, aluoutM, regwriteM, zeroM} !== 35'd0) begin
      errors++; $display("FAIL flush_bubble got=%b/%h/%b/%b exp=0/0/0/0", validM, aluoutM, regwriteM, zeroM); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'hFFFF, 32'hFFFF, 3'b100, 1'b1, 5'd2);
    tick();
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    checks++; if ({validM, illegalM, overflowM, aluoutM} !== {3'b110, 32'd0}) begin
      errors++; $display("FAIL illegal got=%b%b%b/%h exp=110/0", validM, illegalM, overflowM, aluoutM); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'd1, 32'd1, 3'b010, 1'b1, 5'd14);
    tick();
    drive(1'b1, 32'd2, 32'd2, 3'b010, 1'b1, 5'd15);
    tick();
    drive(1'b1, 32'd7, 32'd7, 3'b010, 1'b1, 5'd16);
    rst = 1'b1; stall = 1'b1;
    tick();
    checks++; if (obs !== 49'd0) begin errors++; $display("FAIL reset_mid got=%h exp=0", obs); end
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 32'd2, 32'd3, 3'b010, 1'b1, 5'd5);
    tick();
    checks++; if ({validE, validM} !== 2'b10) begin
      errors++; $display("FAIL reset_first_e got=%b exp=10", {validE, validM}); end
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    checks++; if ({validM, aluoutM, writeregM} !== {1'b1, 32'd5, 5'd5}) begin
      errors++; $display("FAIL reset_first_m got=%b/%0d/%0d exp=1/5/5", validM, aluoutM, writeregM); end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      flushE = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      tick();
      checks++; if (obs !== exp_vec()) begin
        errors++; $display("FAIL random[%0d] got=%h exp=%h", i, obs, exp_vec()); end
    end
    rst = 1'b0; stall = 1'b0; flushE = 1'b0;
  endtask

  initial begin
    me = '0;
    mm = '0;
    test_reset();
    test_add();
    test_overflow_slt();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
